// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
// Contents: word type, default reset PC, NOP encoding, fetch FSM state enum.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        WARM    = 2'd1,
        RUN     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - DEPTH-entry FIFO of {pc, word} pairs with flush
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   push_i, push_pc_i,    write one entry at the tail
//   push_word_i
//   pop_i                 drop the head entry (ignored when empty)
//   flush_i               discard all entries; wins over push and pop
//   head_valid_o,         head entry presence and contents
//   head_pc_o, head_word_o
//   count_o               current occupancy
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [31:0]   push_pc_i,
    input  logic [31:0]   push_word_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic          head_valid_o,
    output logic [31:0]   head_pc_o,
    output logic [31:0]   head_word_o,
    output logic [CW-1:0] count_o
);

    // DEPTH is 2 or 4, so the pointers wrap naturally at their width.
    localparam int PW = $clog2(DEPTH);

    word_t         pc_mem   [DEPTH];
    word_t         word_mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            pc_mem[wr_ptr_q]   <= push_pc_i;
            word_mem[wr_ptr_q] <= push_word_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_pc_o    = pc_mem[rd_ptr_q];
    assign head_word_o  = word_mem[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: PC sequencing, imem requests, decode buffer
// Ports:
//   clock, reset                       clock, asynchronous active-high reset
//   imem_req, imem_addr, imem_rdata    instruction memory; rdata one cycle after req
//   redirect_valid, redirect_pc        PC change from writeback
//   instr_valid, instr_ready,          decoder handshake for the buffer head
//   instr, instr_pc
//   redirect_misaligned                pulse after a redirect with pc[1:0] != 0
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        redirect_misaligned
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    word_t         fetch_pc_q, fetch_pc_d;
    word_t         flight_pc_q;
    logic          epoch_q, epoch_d;
    logic          in_flight_q;
    logic          flight_epoch_q;
    logic          misaligned_q;
    logic          issue;
    logic          pop;
    logic          push;
    logic          head_valid;
    logic [31:0]   head_pc;
    logic [31:0]   head_word;
    logic [CW-1:0] count;
    logic [3:0]    reserved;

    assign pop = head_valid && instr_ready;

    // Slots already spoken for: buffered entries plus the outstanding response,
    // less the entry leaving this cycle. Counting the pop keeps the pipe full.
    assign reserved = 4'(count) + 4'(in_flight_q) - 4'(pop);

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;

        case (state_q)
            RESET_S: state_d = WARM;
            WARM:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RESET_S;
        endcase

        if (state_q == RUN && !redirect_valid && reserved < 4'(DEPTH)) begin
            issue = 1'b1;
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            epoch_d    = ~epoch_q;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // A response is kept only if it belongs to the current epoch and no flush
    // is happening on the same edge.
    assign push = in_flight_q && (flight_epoch_q == epoch_q) && !redirect_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= RESET_S;
            fetch_pc_q     <= RESET_PC;
            flight_pc_q    <= RESET_PC;
            epoch_q        <= 1'b0;
            in_flight_q    <= 1'b0;
            flight_epoch_q <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            epoch_q        <= epoch_d;
            in_flight_q    <= issue;
            flight_epoch_q <= epoch_q;
            misaligned_q   <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (issue) begin
                flight_pc_q <= fetch_pc_q;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buffer (
        .clk_i        (clock),
        .rst_i        (reset),
        .push_i       (push),
        .push_pc_i    (flight_pc_q),
        .push_word_i  (imem_rdata),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_word_o  (head_word),
        .count_o      (count)
    );

    assign imem_req            = issue;
    assign imem_addr           = fetch_pc_q;
    assign instr_valid         = head_valid;
    assign instr               = head_valid ? head_word : NOP_INSTR;
    assign instr_pc            = head_valid ? head_pc : 32'h0000_0000;
    assign redirect_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a stream-level model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_misaligned;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the next PC the decoder must see, the next address
    // memory must be asked for, and requests issued but not yet consumed.
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          outstanding;
    logic        exp_mis;
    logic        pend;
    logic [31:0] pend_addr;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr               (instr),
        .instr_pc            (instr_pc),
        .redirect_misaligned (redirect_misaligned)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endfunction

    task automatic model_reset();
        exp_pc      = RESET_PC;
        exp_fetch   = RESET_PC;
        outstanding = 0;
        exp_mis     = 1'b0;
        pend        = 1'b0;
    endtask

    // Called at a settled sample point: advance the model with this cycle's
    // activity, cross the clock edge, then play memory for the new cycle.
    task automatic tick();
        if (redirect_valid) begin
            exp_pc      = {redirect_pc[31:2], 2'b00};
            exp_fetch   = {redirect_pc[31:2], 2'b00};
            outstanding = 0;
            exp_mis     = (redirect_pc[1:0] != 2'b00);
        end else begin
            exp_mis = 1'b0;
            if (instr_valid && instr_ready) begin
                exp_pc      = exp_pc + 32'd4;
                outstanding = outstanding - 1;
            end
            if (imem_req) begin
                exp_fetch   = exp_fetch + 32'd4;
                outstanding = outstanding + 1;
            end
        end
        pend      = imem_req;
        pend_addr = imem_addr;
        @(posedge clock);
        @(negedge clock);
        imem_rdata = pend ? mem(pend_addr) : $urandom;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0302;
        instr_ready    = 1'b1;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
        vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        vectors++; if (instr !== 32'h0000_0013) begin miscompares++; $display("FAIL rst_instr: got %h want 00000013", instr); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        @(posedge clock);
        @(negedge clock);
        vectors++; if (redirect_misaligned !== 1'b0) begin miscompares++; $display("FAIL rst_mis: got %b want 0", redirect_misaligned); end
        redirect_valid = 1'b0;
        reset          = 1'b0;
        model_reset();
        // Sample 1 is the WARM cycle (cycle 0); the first request lands in
        // cycle 1 and its instruction is visible in cycle 3.
        for (int s = 0; s < 8; s++) begin
            #1;
            vectors++;
            if (imem_req !== 1'(s >= 2)) begin miscompares++; $display("FAIL start_req s%0d: got %b want %b", s, imem_req, (s >= 2)); end
            if (s >= 2) begin
                vectors++;
                if (imem_addr !== RESET_PC + 32'(4 * (s - 2))) begin miscompares++; $display("FAIL start_addr s%0d: got %h want %h", s, imem_addr, RESET_PC + 32'(4 * (s - 2))); end
            end
            vectors++;
            if (instr_valid !== 1'(s >= 4)) begin miscompares++; $display("FAIL start_valid s%0d: got %b want %b", s, instr_valid, (s >= 4)); end
            if (s >= 4) begin
                vectors++;
                if (instr_pc !== RESET_PC + 32'(4 * (s - 4)) || instr !== mem(RESET_PC + 32'(4 * (s - 4)))) begin
                    miscompares++; $display("FAIL start_instr s%0d: got pc %h word %h want pc %h", s, instr_pc, instr, RESET_PC + 32'(4 * (s - 4)));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc = 32'h0;
        logic [31:0] held_word = 32'h0;
        int          reqs = 0;
        instr_ready = 1'b0;
        for (int s = 0; s < 6; s++) begin
            #1;
            if (s == 0) begin
                held_pc   = instr_pc;
                held_word = instr;
                vectors++;
                if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL stall_head: got %h want %h", instr_pc, exp_pc); end
            end
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== held_pc || instr !== held_word) begin
                miscompares++; $display("FAIL stall_hold s%0d: got v%b pc %h word %h want pc %h word %h", s, instr_valid, instr_pc, instr, held_pc, held_word);
            end
            if (imem_req) begin
                reqs++;
                vectors++;
                if (imem_addr !== exp_fetch) begin miscompares++; $display("FAIL stall_addr: got %h want %h", imem_addr, exp_fetch); end
            end
            tick();
            vectors++;
            if (outstanding > DEPTH) begin miscompares++; $display("FAIL stall_bound: got %0d want <= %0d", outstanding, DEPTH); end
        end
        vectors++;
        if (reqs > DEPTH) begin miscompares++; $display("FAIL stall_reqs: got %0d want <= %0d", reqs, DEPTH); end
        instr_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            #1;
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem(exp_pc)) begin
                miscompares++; $display("FAIL resume s%0d: got v%b pc %h word %h want pc %h", s, instr_valid, instr_pc, instr, exp_pc);
            end
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        bit found = 1'b0;
        bit seen  = 1'b0;
        do_reset();
        instr_ready = 1'b1;
        for (int s = 0; s < 20 && !found; s++) begin
            #1;
            if (imem_req && imem_addr == RESET_PC + 32'd8) found = 1'b1;
            tick();
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL redir_setup: got no fetch of %h want one", RESET_PC + 32'd8); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL redir_req: got %b want 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        for (int s = 0; s < 12; s++) begin
            #1;
            if (s == 0) begin
                vectors++;
                if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got %b want 0", instr_valid); end
            end
            if (instr_valid) begin
                vectors++;
                if (instr_pc === RESET_PC + 32'd8) begin miscompares++; $display("FAIL redir_stale: got pc %h want anything else", instr_pc); end
                if (!seen) begin
                    seen = 1'b1;
                    vectors++;
                    if (instr_pc !== 32'h100 || instr !== mem(32'h100)) begin miscompares++; $display("FAIL redir_first: got %h want 00000100", instr_pc); end
                end
            end
            tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL redir_timeout: got no instruction want pc 00000100"); end
    endtask

    task automatic test_misaligned();
        bit seen = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req: got %b want 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (redirect_misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_pulse: got %b want 1", redirect_misaligned); end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL mis_addr: got req %b addr %h want 1 00000200", imem_req, imem_addr); end
        tick();
        #1;
        vectors++;
        if (redirect_misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_once: got %b want 0", redirect_misaligned); end
        for (int s = 0; s < 10 && !seen; s++) begin
            if (s > 0) #1;
            if (instr_valid) begin
                seen = 1'b1;
                vectors++;
                if (instr_pc !== 32'h200 || instr !== mem(32'h200)) begin miscompares++; $display("FAIL mis_first: got %h want 00000200", instr_pc); end
            end
            tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL mis_timeout: got no instruction want pc 00000200"); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0: got %b %h want 1 fffffffc", imem_req, imem_addr); end
        tick();
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1: got %b %h want 1 00000000", imem_req, imem_addr); end
        tick();
        #1;
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== mem(32'hFFFF_FFFC)) begin miscompares++; $display("FAIL wrap_instr0: got v%b pc %h want fffffffc", instr_valid, instr_pc); end
        tick();
        #1;
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem(32'h0)) begin miscompares++; $display("FAIL wrap_instr1: got v%b pc %h want 00000000", instr_valid, instr_pc); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt = 32'h0;
        bit seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tgt            = $urandom & 32'hFFFF_FFFC;
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
            #1;
            vectors++;
            if (imem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_req k%0d: got %b want 0", k, imem_req); end
            tick();
        end
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_flush: got %b want 0", instr_valid); end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== tgt) begin miscompares++; $display("FAIL b2b_addr: got %b %h want 1 %h", imem_req, imem_addr, tgt); end
        tick();
        for (int s = 0; s < 10 && !seen; s++) begin
            #1;
            if (instr_valid) begin
                seen = 1'b1;
                vectors++;
                if (instr_pc !== tgt || instr !== mem(tgt)) begin miscompares++; $display("FAIL b2b_first: got %h want %h", instr_pc, tgt); end
            end
            tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL b2b_timeout: got no instruction want pc %h", tgt); end
    endtask

    task automatic test_reset_midflight();
        bit          found = 1'b0;
        bit          seen  = 1'b0;
        logic [31:0] stale = 32'h0;
        instr_ready = 1'b1;
        for (int s = 0; s < 10 && !found; s++) begin
            #1;
            if (imem_req) found = 1'b1;
            tick();
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL mid_setup: got no request want one"); end
        // The response to that request is on imem_rdata now; reset lands first.
        stale = imem_rdata;
        reset = 1'b1;
        #1;
        vectors++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            miscompares++; $display("FAIL mid_clear: got v%b req %b addr %h want 0 0 %h", instr_valid, imem_req, imem_addr, RESET_PC);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        imem_rdata = stale;
        for (int s = 0; s < 12; s++) begin
            #1;
            if (instr_valid) begin
                vectors++;
                if (instr_pc !== exp_pc || instr !== mem(exp_pc)) begin miscompares++; $display("FAIL mid_stream: got pc %h word %h want pc %h", instr_pc, instr, exp_pc); end
                if (!seen) begin
                    seen = 1'b1;
                    vectors++;
                    if (instr_pc !== RESET_PC || instr === stale) begin miscompares++; $display("FAIL mid_restart: got pc %h word %h want pc %h", instr_pc, instr, RESET_PC); end
                end
            end
            tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL mid_timeout: got no instruction want pc %h", RESET_PC); end
    endtask

    task automatic test_random();
        bit          prev_hold  = 1'b0;
        bit          prev_redir = 1'b0;
        logic [31:0] prev_pc    = 32'h0;
        logic [31:0] prev_word  = 32'h0;
        for (int c = 0; c < 400; c++) begin
            instr_ready    = 1'($urandom_range(0, 9) < 7);
            redirect_valid = 1'($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            #1;
            if (prev_hold) begin
                vectors++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr !== prev_word) begin
                    miscompares++; $display("FAIL rnd_hold c%0d: got v%b pc %h want pc %h", c, instr_valid, instr_pc, prev_pc);
                end
            end
            if (prev_redir) begin
                vectors++;
                if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_flush c%0d: got %b want 0", c, instr_valid); end
            end
            vectors++;
            if (redirect_misaligned !== exp_mis) begin miscompares++; $display("FAIL rnd_mis c%0d: got %b want %b", c, redirect_misaligned, exp_mis); end
            if (instr_valid && instr_ready) begin
                vectors++;
                if (instr_pc !== exp_pc || instr !== mem(exp_pc)) begin miscompares++; $display("FAIL rnd_stream c%0d: got pc %h word %h want pc %h", c, instr_pc, instr, exp_pc); end
            end
            if (redirect_valid) begin
                vectors++;
                if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rnd_redir_req c%0d: got %b want 0", c, imem_req); end
            end else if (imem_req) begin
                vectors++;
                if (imem_addr !== exp_fetch) begin miscompares++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, exp_fetch); end
            end
            prev_hold  = instr_valid && !instr_ready && !redirect_valid;
            prev_redir = redirect_valid;
            prev_pc    = instr_pc;
            prev_word  = instr;
            tick();
            vectors++;
            if (outstanding > DEPTH || outstanding < 0) begin miscompares++; $display("FAIL rnd_bound c%0d: got %0d want 0..%0d", c, outstanding, DEPTH); end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stall();
        test_redirect_inflight();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
